// File: rtl/seven_segment_monitor_if.sv
// Status/stimulus bundle for seven_segment_monitor.
//   segments_in  : raw segment pins, bit0=seg1(top) .. bit6=seg7(middle)
//   clear_errors : synchronous clear of error_count
//   io_oeb       : pad output-enable (constant, pads are inputs)
//   digit, digit_strobe, period_count, period_valid, invalid_pattern,
//   sequence_error, error_count, stalled : monitor results
// master = the side driving the pins (bench / pad ring), slave = the monitor.
interface seven_segment_monitor_if;
  logic [6:0]  segments_in;
  logic        clear_errors;
  logic [6:0]  io_oeb;
  logic [3:0]  digit;
  logic        digit_strobe;
  logic [23:0] period_count;
  logic        period_valid;
  logic        invalid_pattern;
  logic        sequence_error;
  logic [7:0]  error_count;
  logic        stalled;

  modport master (
    output segments_in, clear_errors,
    input  io_oeb, digit, digit_strobe, period_count, period_valid,
           invalid_pattern, sequence_error, error_count, stalled
  );

  modport slave (
    input  segments_in, clear_errors,
    output io_oeb, digit, digit_strobe, period_count, period_valid,
           invalid_pattern, sequence_error, error_count, stalled
  );
endinterface

// File: rtl/seven_segment_monitor.sv
// seven_segment_monitor: receive-side checker for a counting 7-segment bus.
// Synchronises and debounces the segment pins, decodes accepted patterns to
// digits, checks the 0..9 wrap sequence, measures the digit period in clocks
// and keeps a saturating error count.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus        : seven_segment_monitor_if.slave (pins in, status out)
//   vccd1/vssd1: power pins, only with USE_POWER_PINS
module seven_segment_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic [23:0] STALL_CYCLES  = 24'hFFFFFF
) (
`ifdef USE_POWER_PINS
  inout wire vccd1,
  inout wire vssd1,
`endif
  input  logic                          clk,
  input  logic                          reset,
  seven_segment_monitor_if.slave        bus
);

  localparam int unsigned    CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic {ACQUIRE, LOCKED} state_t;

  logic [6:0]    sync1, sync2, cand, accepted;
  logic [CW-1:0] cnt, cnt_next;
  logic          same, reached, accept;
  logic          dec_valid;
  logic [3:0]    dec_digit, exp_next;
  logic          err_event;

  state_t        state;
  logic [3:0]    digit_q;
  logic          strobe_q, pv_q, inv_q, seq_q;
  logic [23:0]   ctr, period_q;
  logic [7:0]    err_q;

  // Run-length filter: the sample that loads a new candidate counts as the
  // first of the run, so acceptance lands on the STABLE_CYCLES-th equal sample.
  // 'reached' fires once per run; 'accept' only when the pattern changed.
  always_comb begin
    same = (sync2 == cand);
    if (!same)
      cnt_next = CW'(1);
    else if (cnt == CNT_MAX)
      cnt_next = cnt;
    else
      cnt_next = cnt + CW'(1);
    reached = (cnt_next == CNT_MAX) && !(same && (cnt == CNT_MAX));
    accept  = reached && (sync2 != accepted);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      cand     <= '0;
      cnt      <= '0;
      accepted <= '0;
    end else begin
      sync1 <= bus.segments_in;
      sync2 <= sync1;
      cand  <= sync2;
      cnt   <= cnt_next;
      if (reached)
        accepted <= sync2;
    end
  end

  always_comb begin
    dec_valid = 1'b1;
    dec_digit = 4'd0;
    case (sync2)
      7'b0111111: dec_digit = 4'd0;
      7'b0000110: dec_digit = 4'd1;
      7'b1011011: dec_digit = 4'd2;
      7'b1001111: dec_digit = 4'd3;
      7'b1100110: dec_digit = 4'd4;
      7'b1101101: dec_digit = 4'd5;
      7'b1111100: dec_digit = 4'd6;
      7'b0000111: dec_digit = 4'd7;
      7'b1111111: dec_digit = 4'd8;
      7'b1100111: dec_digit = 4'd9;
      default:    dec_valid = 1'b0;
    endcase
  end

  assign exp_next  = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
  assign err_event = accept &&
                     (!dec_valid || ((state == LOCKED) && (dec_digit != exp_next)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ACQUIRE;
      digit_q  <= '0;
      strobe_q <= 1'b0;
      pv_q     <= 1'b0;
      inv_q    <= 1'b0;
      seq_q    <= 1'b0;
      ctr      <= '0;
      period_q <= '0;
      err_q    <= '0;
    end else begin
      strobe_q <= 1'b0;
      pv_q     <= 1'b0;
      inv_q    <= 1'b0;
      seq_q    <= 1'b0;

      // An event coinciding with the clear still counts.
      if (bus.clear_errors)
        err_q <= {7'd0, err_event};
      else if (err_event && (err_q != '1))
        err_q <= err_q + 8'd1;

      case (state)
        ACQUIRE: begin
          if (accept) begin
            if (dec_valid) begin
              digit_q  <= dec_digit;
              strobe_q <= 1'b1;
              ctr      <= '0;
              state    <= LOCKED;
            end else begin
              inv_q <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (accept && dec_valid) begin
            digit_q  <= dec_digit;
            strobe_q <= 1'b1;
            pv_q     <= 1'b1;
            period_q <= (ctr == '1) ? ctr : ctr + 24'd1;
            seq_q    <= (dec_digit != exp_next);
            ctr      <= '0;
          end else if (accept) begin
            inv_q <= 1'b1;
            state <= ACQUIRE;
          end else if (ctr != '1) begin
            ctr <= ctr + 24'd1;
          end
        end
        default: state <= ACQUIRE;
      endcase
    end
  end

  assign bus.io_oeb          = '1;
  assign bus.digit           = digit_q;
  assign bus.digit_strobe    = strobe_q;
  assign bus.period_count    = period_q;
  assign bus.period_valid    = pv_q;
  assign bus.invalid_pattern = inv_q;
  assign bus.sequence_error  = seq_q;
  assign bus.error_count     = err_q;
  assign bus.stalled         = (state == LOCKED) && (ctr >= STALL_CYCLES);

endmodule

// File: tb/tb_seven_segment_monitor.sv
module tb_seven_segment_monitor;

  localparam int          STABLE = 4;
  localparam logic [23:0] STALL  = 24'd50;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seven_segment_monitor_if bus();

  seven_segment_monitor #(.STABLE_CYCLES(STABLE), .STALL_CYCLES(STALL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] pat_tab [10];

  // Reference model state
  logic [6:0]  m_pins [$];
  logic [6:0]  m_samp [$];
  logic [6:0]  m_acc;
  bit          m_locked;
  logic [3:0]  m_digit;
  int          m_ctr;
  logic [23:0] m_period;
  int          m_err;
  bit          m_strobe, m_pv, m_inv, m_seq;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    m_pins.delete();
    m_samp.delete();
    m_acc = '0; m_locked = 0; m_digit = '0; m_ctr = 0; m_period = '0; m_err = 0;
    m_strobe = 0; m_pv = 0; m_inv = 0; m_seq = 0;
  endtask

  // Per-clock reference: a sample is the pin value two clocks earlier; a
  // pattern is taken once it has been seen STABLE times in a row and differs
  // from the last taken pattern.
  task automatic model_step(input logic [6:0] pin, input bit clr, input bit rst);
    logic [6:0] s;
    int run, idx;
    bit ev;
    m_strobe = 0; m_pv = 0; m_inv = 0; m_seq = 0;
    if (rst) begin
      model_reset();
      return;
    end
    m_pins.push_back(pin);
    s = (m_pins.size() >= 3) ? m_pins[m_pins.size()-3] : 7'h00;
    if (m_pins.size() > 3) void'(m_pins.pop_front());
    m_samp.push_back(s);
    if (m_samp.size() > STABLE + 1) void'(m_samp.pop_front());
    run = 0;
    for (int i = m_samp.size() - 1; i >= 0; i--) begin
      if (m_samp[i] != s) break;
      run++;
    end
    ev = 0;
    if (run == STABLE && s != m_acc) begin
      m_acc = s;
      idx = -1;
      for (int k = 0; k < 10; k++) if (pat_tab[k] == s) idx = k;
      if (idx < 0) begin
        m_inv = 1; ev = 1; m_locked = 0;
      end else begin
        if (m_locked) begin
          m_pv = 1;
          m_period = (m_ctr + 1 > 24'hFFFFFF) ? 24'hFFFFFF : 24'(m_ctr + 1);
          if (idx != (int'(m_digit) + 1) % 10) begin m_seq = 1; ev = 1; end
        end
        m_locked = 1;
        m_digit  = 4'(idx);
        m_strobe = 1;
        m_ctr    = 0;
      end
    end else if (m_locked && m_ctr < 24'hFFFFFF) begin
      m_ctr++;
    end
    if (clr) m_err = ev ? 1 : 0;
    else if (ev && m_err < 255) m_err++;
  endtask

  function automatic logic [47:0] dut_vec();
    return {bus.digit, bus.digit_strobe, bus.period_count, bus.period_valid,
            bus.invalid_pattern, bus.sequence_error, bus.error_count,
            bus.stalled, bus.io_oeb};
  endfunction

  function automatic logic [47:0] model_vec();
    return {m_digit, m_strobe, m_period, m_pv, m_inv, m_seq, 8'(m_err),
            (m_locked && m_ctr >= int'(STALL)), 7'h7F};
  endfunction

  task automatic step(input logic [6:0] pin, input bit clr, input bit rst);
    bus.segments_in  = pin;
    bus.clear_errors = clr;
    reset            = rst;
    @(posedge clk);
    model_step(pin, clr, rst);
    #1;
    chk("model", dut_vec(), model_vec());
    @(negedge clk);
  endtask

  typedef struct {
    logic [6:0]  seg;
    int          hold;
    bit          clr;
    logic [3:0]  e_digit;
    bit          e_pv;
    logic [23:0] e_period;
    bit          e_seq;
    logic [7:0]  e_err;
  } vec_t;

  vec_t tab [14];

  initial begin
    bit early;
    int last;
    logic [6:0] p;

    pat_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

    for (int i = 0; i < 10; i++)
      tab[i] = '{pat_tab[i], 100, 0, 4'(i), (i > 0), 24'd100, 0, 8'd0};
    tab[10] = '{7'h3F, 100, 0, 4'd0, 1, 24'd100, 0, 8'd0};
    tab[11] = '{7'h06, 100, 0, 4'd1, 1, 24'd100, 0, 8'd0};
    tab[12] = '{7'h4F, 100, 0, 4'd3, 1, 24'd100, 1, 8'd1};
    tab[13] = '{7'h66, 100, 1, 4'd4, 1, 24'd100, 0, 8'd0};

    model_reset();
    bus.segments_in  = '0;
    bus.clear_errors = 1'b0;
    reset            = 1'b1;

    // Reset with noisy inputs: everything must read zero (io_oeb all ones).
    for (int i = 0; i < 3; i++) step(7'h3F, 1, 1);
    chk("reset_outputs", dut_vec(), {41'd0, 7'h7F});
    for (int i = 0; i < 5; i++) step(7'h00, 0, 0);

    // Table: one pattern per record, strobe expected on exactly the 6th clock.
    for (int r = 0; r < 14; r++) begin
      early = 0;
      for (int k = 1; k <= tab[r].hold; k++) begin
        step(tab[r].seg, tab[r].clr, 0);
        if (k < 6) early |= bus.digit_strobe;
        if (k == 6) begin
          chk("early_strobe", 48'(early), 48'd0);
          chk("strobe", 48'(bus.digit_strobe), 48'd1);
          chk("digit", 48'(bus.digit), 48'(tab[r].e_digit));
          chk("period_valid", 48'(bus.period_valid), 48'(tab[r].e_pv));
          if (tab[r].e_pv) chk("period", 48'(bus.period_count), 48'(tab[r].e_period));
          chk("seq_err", 48'(bus.sequence_error), 48'(tab[r].e_seq));
          chk("err_count", 48'(bus.error_count), 48'(tab[r].e_err));
        end
      end
    end

    // Short glitch inside digit 4: ignored, period keeps running.
    early = 0;
    for (int k = 0; k < 2; k++)  begin step(7'h7F, 0, 0); early |= bus.digit_strobe; end
    for (int k = 0; k < 20; k++) begin step(7'h66, 0, 0); early |= bus.digit_strobe; end
    chk("glitch2_no_strobe", 48'(early), 48'd0);
    for (int k = 1; k <= 6; k++) step(7'h6D, 0, 0);
    chk("after_glitch_digit", 48'(bus.digit), 48'd5);
    chk("after_glitch_period", {bus.period_valid, bus.period_count}, {1'b1, 24'd122});
    for (int k = 0; k < 20; k++) step(7'h6D, 0, 0);

    // Glitch held STABLE clocks is taken as an 8, then the 5 comes back.
    for (int k = 1; k <= 10; k++) begin
      step((k <= 4) ? 7'h7F : 7'h6D, 0, 0);
      if (k == 6)  chk("glitch4_is_8", {bus.digit_strobe, bus.digit, bus.sequence_error, bus.error_count},
                       {1'b1, 4'd8, 1'b1, 8'd1});
      if (k == 10) chk("back_to_5", {bus.digit_strobe, bus.digit, bus.sequence_error, bus.error_count},
                       {1'b1, 4'd5, 1'b1, 8'd2});
    end
    for (int k = 0; k < 20; k++) step(7'h6D, 0, 0);

    // Blank pattern drops lock; the next digit re-acquires without checks.
    for (int k = 1; k <= 6; k++) step(7'h00, 0, 0);
    chk("blank_invalid", {bus.invalid_pattern, bus.digit_strobe, bus.digit, bus.error_count},
        {1'b1, 1'b0, 4'd5, 8'd3});
    for (int k = 1; k <= 6; k++) step(7'h7C, 0, 0);
    chk("reacquire_6", {bus.digit_strobe, bus.digit, bus.period_valid, bus.sequence_error, bus.error_count},
        {1'b1, 4'd6, 1'b0, 1'b0, 8'd3});
    for (int k = 0; k < 10; k++) step(7'h7C, 0, 0);

    // Clear in the same clock as an error event leaves a count of one.
    for (int k = 1; k <= 6; k++) step(7'h00, (k == 6), 0);
    chk("clear_with_event", {bus.invalid_pattern, bus.error_count}, {1'b1, 8'd1});
    for (int k = 0; k < 4; k++) step(7'h00, 0, 0);

    // Stall detection on a held digit 3, then reset in the middle of it.
    for (int k = 1; k <= 6; k++) step(7'h4F, 0, 0);
    chk("digit3_strobe", {bus.digit_strobe, bus.digit, bus.period_valid}, {1'b1, 4'd3, 1'b0});
    for (int k = 1; k <= 60; k++) begin
      step(7'h4F, 0, 0);
      if (k == 49) chk("stall_before", 48'(bus.stalled), 48'd0);
      if (k == 50) chk("stall_at", 48'(bus.stalled), 48'd1);
    end
    step(7'h4F, 0, 1);
    chk("stall_reset", {bus.stalled, bus.digit, bus.error_count}, {1'b0, 4'd0, 8'd0});
    step(7'h4F, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      step(7'h4F, 0, 0);
      if (k == 6) chk("post_reset_strobe", {bus.digit_strobe, bus.digit}, {1'b1, 4'd3});
    end

    // Random mix of sequential digits, out-of-order digits and junk codes.
    last = 3;
    for (int n = 0; n < 400; n++) begin
      int sel, hold;
      sel = $urandom_range(0, 99);
      if (sel < 50)      begin last = (last + 1) % 10; p = pat_tab[last]; end
      else if (sel < 75) begin last = $urandom_range(0, 9); p = pat_tab[last]; end
      else               p = 7'($urandom_range(0, 127));
      hold = $urandom_range(1, 10);
      for (int k = 0; k < hold; k++)
        step(p, ($urandom_range(0, 99) < 3), ($urandom_range(0, 199) == 0));
    end

    // Junk-heavy stream with no clears to drive error_count into saturation.
    for (int n = 0; n < 600; n++) begin
      p = 7'($urandom_range(0, 127));
      for (int k = 0; k < $urandom_range(4, 6); k++) step(p, 0, 0);
    end
    chk("err_saturated", 48'(bus.error_count), 48'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
